pulse_period_meter: RTL and testbench
=====================================

# pulse_period_meter

Measures the interval, in `clk` cycles, between successive rising edges of a pulse stream, such as the periodic strobe produced by the design's programmable timer. It reports each completed period with a one-cycle valid strobe and flags loss of the pulse stream via a programmable timeout. It sits on the consumer side of any periodic-pulse interface and is used for self-check of timer programming and for frequency monitoring.

## Interface
- `WIDTH`, default 25: width of the period counter, the measured period and the timeout limit.
- `clk`  input  1: clock.
- `rst`  input  1: reset, synchronous, active-high.
- `en`  input  1: measurement enable; low forces IDLE.
- `pulse_in`  input  1: pulse stream under measurement; only rising edges matter.
- `timeout_limit`  input  WIDTH: cycles without an edge before timeout; 0 disables timeout.
- `period`  output  WIDTH: last measured period in cycles; held between updates.
- `period_valid`  output  1: one-cycle strobe when `period` updates.
- `timeout`  output  1: one-cycle strobe on loss of pulse stream.
- `measuring`  output  1: high while in MEASURE state.

## Operation
- Edge detect: `rise = pulse_in & ~pulse_d`. `pulse_d` is a register that tracks `pulse_in` every cycle, regardless of `en` or state. It resets to 0, so a `pulse_in` that is high out of reset counts as a rise.
- Counter `cnt` is WIDTH bits wide.
- States: IDLE, WAIT_FIRST, MEASURE.
  - IDLE: `cnt`=0. Go to WAIT_FIRST when `en`=1.
  - WAIT_FIRST: on `rise`, `cnt`<=1 and go to MEASURE. No output is produced.
  - MEASURE: if `rise`, then `period`<=`cnt`, `period_valid`<=1, `cnt`<=1, and stay in MEASURE.
  - MEASURE, no `rise`: if `timeout_limit`!=0 and `cnt`==`timeout_limit`, or `cnt`==all-ones, then `timeout`<=1 and go to WAIT_FIRST. `period` is unchanged. Otherwise `cnt`<=`cnt`+1.
- Period definition: for rises detected in cycles E1 and E2, the reported `period` is E2−E1. A timer that pulses every L+1 cycles reads as L+1.
- In any state, `en`=0 sends the block to IDLE on the next edge and clears `cnt`. `period` holds its value. No strobes are produced.
- Simultaneous rise and timeout condition: the rise wins. The period is reported and no timeout is raised.
- `pulse_in` held high continuously produces no rise, so the block ends in timeout, or idles forever in WAIT_FIRST.
- All arithmetic is unsigned modulo 2^WIDTH. Saturation at all-ones is treated as a timeout, so `cnt` never wraps.

## Timing
- Reset values: `period`=0, `period_valid`=0, `timeout`=0, `measuring`=0, state=IDLE, `cnt`=0, `pulse_d`=0.
- All outputs are registered.
- Latency: a rise present on `pulse_in` at clock edge k gives `period_valid`=1 during cycle k+1 (one cycle). With the sync option enabled, latency is k+3.
- `timeout` is asserted during the cycle after the edge on which `cnt`==`timeout_limit` is sampled. The first timeout therefore occurs `timeout_limit` cycles after the last rise.
- `measuring` rises in the cycle after the first rise and falls in the cycle after a timeout or `en`=0.
- `rst` mid-measurement: all state returns to reset values on the next edge and no strobe is emitted.
- Back-to-back rises need a gap of at least 2 cycles; the minimum reportable `period` is 2.

## Configuration
- `PULSE_METER_SYNC_EN`
  - Defined: `pulse_in` passes through a 2-flop synchronizer before edge detect. Use this for asynchronous sources. Adds 2 cycles of latency; periods are unchanged.
  - Undefined: `pulse_in` is assumed synchronous to `clk` and feeds edge detect directly.

## Structure
- Package `pulse_meter_pkg`:
  - state encoding constants `ST_IDLE`=2'd0, `ST_WAIT_FIRST`=2'd1, `ST_MEASURE`=2'd2;
  - default `WIDTH` constant.
- Sub-module `pulse_edge_sync`:
  - contains the optional synchronizer and `pulse_d`;
  - outputs `rise`.
- The FSM, counter and output registers stay in `pulse_period_meter`.

## Test plan
- `timer` with limit=9 drives `pulse_in`, `en`=1, `timeout_limit`=0: after the first rise, every `period_valid` shows `period`=10; `measuring`=1.
- Rises 5 cycles apart, `timeout_limit`=5: rise and limit coincide, so `period`=5 is reported each time and `timeout` never asserts.
- One rise then no more, `timeout_limit`=20: `timeout` pulses once 20 cycles after the rise; state returns to WAIT_FIRST; `period` keeps its previous value; `measuring` drops.
- WIDTH=4, `timeout_limit`=0, single rise: `cnt` reaches 15 and `timeout` pulses; no wrap-around and no `period_valid`.
- `rst`=1 or `en`=0 for one cycle mid-MEASURE at `cnt`=7: no strobe; the next two rises 12 cycles apart give `period`=12 (the first rise only re-arms).
- `PULSE_METER_SYNC_EN` build with the same stimulus as test 1: identical periods, with `period_valid` delayed by 2 cycles.

Source files
------------

// File: rtl/pulse_meter_pkg.sv
// Shared constants for the pulse period meter: FSM state encoding and default counter width.
package pulse_meter_pkg;

    localparam int PULSE_METER_WIDTH = 25;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_WAIT_FIRST = 2'd1,
        ST_MEASURE    = 2'd2
    } meter_state_e;

endpackage

// File: rtl/pulse_edge_sync.sv
// Rising-edge detector for the measured pulse stream.
// With PULSE_METER_SYNC_EN defined, pulse_in first passes a 2-flop synchronizer.
module pulse_edge_sync
    import pulse_meter_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic pulse_in,
    output logic rise
);

    logic pulse_s;
    logic pulse_d_q;

`ifdef PULSE_METER_SYNC_EN
    logic sync1_q;
    logic sync2_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= pulse_in;
            sync2_q <= sync1_q;
        end
    end

    assign pulse_s = sync2_q;
`else
    assign pulse_s = pulse_in;
`endif

    // Tracks the stream every cycle regardless of enable, so a level already high counts once only.
    always_ff @(posedge clk) begin
        if (rst) begin
            pulse_d_q <= 1'b0;
        end else begin
            pulse_d_q <= pulse_s;
        end
    end

    assign rise = pulse_s & ~pulse_d_q;

endmodule

// File: rtl/pulse_period_meter.sv
// Measures clk cycles between rising edges of pulse_in and flags stream loss via timeout.
// Build option: PULSE_METER_SYNC_EN adds a 2-flop input synchronizer (+2 cycles latency).
//
// state          | meaning
// ST_IDLE        | disabled, counter cleared
// ST_WAIT_FIRST  | armed, waiting for the first rise to start a period
// ST_MEASURE     | counting cycles since the last rise
module pulse_period_meter
    import pulse_meter_pkg::*;
#(
    parameter int WIDTH = PULSE_METER_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             pulse_in,
    input  logic [WIDTH-1:0] timeout_limit,
    output logic [WIDTH-1:0] period,
    output logic             period_valid,
    output logic             timeout,
    output logic             measuring
);

    meter_state_e     state_q;
    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;
    logic [WIDTH-1:0] period_q;
    logic             period_valid_q;
    logic             timeout_q;
    logic             measuring_q;
    logic             rise;
    logic             limit_hit;

    pulse_edge_sync u_edge (
        .clk      (clk),
        .rst      (rst),
        .pulse_in (pulse_in),
        .rise     (rise)
    );

    assign cnt_d = cnt_q + 1'b1;

    // Saturation counts as a timeout so the counter never wraps.
    assign limit_hit = ((timeout_limit != '0) && (cnt_q == timeout_limit)) || (&cnt_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            cnt_q          <= '0;
            period_q       <= '0;
            period_valid_q <= 1'b0;
            timeout_q      <= 1'b0;
            measuring_q    <= 1'b0;
        end else begin
            period_valid_q <= 1'b0;
            timeout_q      <= 1'b0;
            if (!en) begin
                state_q     <= ST_IDLE;
                cnt_q       <= '0;
                measuring_q <= 1'b0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        cnt_q   <= '0;
                        state_q <= ST_WAIT_FIRST;
                    end
                    ST_WAIT_FIRST: begin
                        if (rise) begin
                            cnt_q       <= {{(WIDTH-1){1'b0}}, 1'b1};
                            state_q     <= ST_MEASURE;
                            measuring_q <= 1'b1;
                        end
                    end
                    ST_MEASURE: begin
                        // A rise coinciding with the limit still reports a period.
                        if (rise) begin
                            period_q       <= cnt_q;
                            period_valid_q <= 1'b1;
                            cnt_q          <= {{(WIDTH-1){1'b0}}, 1'b1};
                        end else if (limit_hit) begin
                            timeout_q   <= 1'b1;
                            cnt_q       <= '0;
                            state_q     <= ST_WAIT_FIRST;
                            measuring_q <= 1'b0;
                        end else begin
                            cnt_q <= cnt_d;
                        end
                    end
                    default: begin
                        state_q     <= ST_IDLE;
                        cnt_q       <= '0;
                        measuring_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign period       = period_q;
    assign period_valid = period_valid_q;
    assign timeout      = timeout_q;
    assign measuring    = measuring_q;

endmodule

// File: tb/tb_pulse_period_meter.sv
// Self-checking bench: a WIDTH=25 and a WIDTH=4 meter share stimulus and are checked against a timestamp model.
module tb_pulse_period_meter;

`ifdef PULSE_METER_SYNC_EN
    localparam int SYNC_DLY = 2;
`else
    localparam int SYNC_DLY = 0;
`endif
    localparam int MAX_A = 33554431;
    localparam int MAX_B = 15;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic        pulse_in = 1'b0;
    logic [24:0] lim_a = '0;
    logic [3:0]  lim_b = '0;
    logic [24:0] period_a;
    logic [3:0]  period_b;
    logic        pv_a, to_a, meas_a;
    logic        pv_b, to_b, meas_b;

    always #5 clk = ~clk;

    pulse_period_meter #(.WIDTH(25)) dut_a (
        .clk(clk), .rst(rst), .en(en), .pulse_in(pulse_in), .timeout_limit(lim_a),
        .period(period_a), .period_valid(pv_a), .timeout(to_a), .measuring(meas_a)
    );

    pulse_period_meter #(.WIDTH(4)) dut_b (
        .clk(clk), .rst(rst), .en(en), .pulse_in(pulse_in), .timeout_limit(lim_b),
        .period(period_b), .period_valid(pv_b), .timeout(to_b), .measuring(meas_b)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;

    // reference model: per-instance timestamps of the last rise
    bit m_idle[2];
    bit m_armed[2];
    bit m_pv[2];
    bit m_to[2];
    bit m_meas[2];
    int m_last[2];
    int m_period[2];
    bit prev_s = 1'b0;
    bit dly1 = 1'b0;
    bit dly2 = 1'b0;

    int seen_pv = 0;
    int seen_to = 0;
    int cur_exp_period = -1;

    typedef struct {
        int gap;
        int limit;
        int nrises;
        int exp_period;
        int exp_valids;
        int exp_timeouts;
    } vec_t;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            if (n_bad <= 40) $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
        end
    endtask

    task automatic model_step(input int i, input bit r_rst, input bit r_en, input bit r_rise,
                              input int lim, input int maxc);
        int el;
        m_pv[i] = 1'b0;
        m_to[i] = 1'b0;
        if (r_rst) begin
            m_idle[i] = 1'b1; m_armed[i] = 1'b0; m_meas[i] = 1'b0;
            m_last[i] = 0; m_period[i] = 0;
        end else if (!r_en) begin
            m_idle[i] = 1'b1; m_armed[i] = 1'b0; m_meas[i] = 1'b0;
        end else if (m_idle[i]) begin
            m_idle[i] = 1'b0;
        end else if (r_rise) begin
            if (m_armed[i]) begin
                m_pv[i] = 1'b1;
                m_period[i] = cyc - m_last[i];
            end
            m_armed[i] = 1'b1;
            m_meas[i] = 1'b1;
            m_last[i] = cyc;
        end else if (m_armed[i]) begin
            el = cyc - m_last[i];
            if ((lim != 0 && el == lim) || el == maxc) begin
                m_to[i] = 1'b1;
                m_armed[i] = 1'b0;
                m_meas[i] = 1'b0;
            end
        end
    endtask

    task automatic step();
        bit s;
        bit r;
        @(posedge clk);
        s = (SYNC_DLY != 0) ? dly2 : pulse_in;
        r = s & ~prev_s;
        if (rst) begin
            prev_s = 1'b0; dly1 = 1'b0; dly2 = 1'b0;
        end else begin
            prev_s = s; dly2 = dly1; dly1 = pulse_in;
        end
        model_step(0, rst, en, r, int'(lim_a), MAX_A);
        model_step(1, rst, en, r, int'(lim_b), MAX_B);
        cyc++;
        #1;
        check("pv_a", int'(pv_a), int'(m_pv[0]));
        check("to_a", int'(to_a), int'(m_to[0]));
        check("meas_a", int'(meas_a), int'(m_meas[0]));
        check("period_a", int'(period_a), m_period[0]);
        check("pv_b", int'(pv_b), int'(m_pv[1]));
        check("to_b", int'(to_b), int'(m_to[1]));
        check("meas_b", int'(meas_b), int'(m_meas[1]));
        check("period_b", int'(period_b), m_period[1]);
        if (pv_a) begin
            seen_pv++;
            if (cur_exp_period >= 0) check("strobe_period", int'(period_a), cur_exp_period);
        end
        if (to_a) seen_to++;
    endtask

    task automatic restart(input int la, input int lb);
        pulse_in = 1'b0; en = 1'b0; rst = 1'b1;
        lim_a = 25'(la); lim_b = 4'(lb);
        step();
        rst = 1'b0; en = 1'b1;
        step();
        step();
    endtask

    task automatic one_rise(input int gap);
        pulse_in = 1'b1;
        step();
        pulse_in = 1'b0;
        repeat (gap - 1) step();
    endtask

    vec_t vecs[6];

    initial begin
        int n;
        vecs[0] = '{gap: 10, limit: 0,  nrises: 5, exp_period: 10, exp_valids: 4, exp_timeouts: 0};
        vecs[1] = '{gap: 5,  limit: 5,  nrises: 6, exp_period: 5,  exp_valids: 5, exp_timeouts: 1};
        vecs[2] = '{gap: 7,  limit: 5,  nrises: 4, exp_period: 0,  exp_valids: 0, exp_timeouts: 4};
        vecs[3] = '{gap: 2,  limit: 0,  nrises: 6, exp_period: 2,  exp_valids: 5, exp_timeouts: 0};
        vecs[4] = '{gap: 20, limit: 20, nrises: 3, exp_period: 20, exp_valids: 2, exp_timeouts: 1};
        vecs[5] = '{gap: 3,  limit: 50, nrises: 4, exp_period: 3,  exp_valids: 3, exp_timeouts: 0};
        for (int i = 0; i < 2; i++) begin
            m_idle[i] = 1'b1; m_armed[i] = 1'b0; m_pv[i] = 1'b0; m_to[i] = 1'b0;
            m_meas[i] = 1'b0; m_last[i] = 0; m_period[i] = 0;
        end

        // reset state
        step();
        step();
        check("rst_period", int'(period_a), 0);
        check("rst_pv", int'(pv_a), 0);
        check("rst_to", int'(to_a), 0);
        check("rst_meas", int'(meas_a), 0);

        // table-driven scenarios
        for (int v = 0; v < 6; v++) begin
            restart(vecs[v].limit, 0);
            seen_pv = 0; seen_to = 0;
            cur_exp_period = vecs[v].exp_period;
            for (int r = 0; r < vecs[v].nrises; r++) one_rise(vecs[v].gap);
            repeat (40) step();
            check("vec_valids", seen_pv, vecs[v].exp_valids);
            check("vec_timeouts", seen_to, vecs[v].exp_timeouts);
            cur_exp_period = -1;
        end

        // timeout 20 cycles after the last rise; period retained
        restart(20, 0);
        one_rise(10);
        check("meas_after_first", int'(meas_a), 1);
        pulse_in = 1'b1;
        step();
        pulse_in = 1'b0;
        n = 0;
        for (int i = 1; i <= 60; i++) begin
            step();
            if (to_a) begin n = i; break; end
        end
        check("timeout_delay", n, 20 + SYNC_DLY);
        check("period_held", int'(period_a), 10);
        check("meas_dropped", int'(meas_a), 0);
        step();
        check("timeout_one_cycle", int'(to_a), 0);

        // WIDTH=4 saturates at 15 and times out with limit 0
        restart(0, 0);
        seen_pv = 0;
        pulse_in = 1'b1;
        step();
        pulse_in = 1'b0;
        n = 0;
        for (int i = 1; i <= 40; i++) begin
            step();
            if (to_b) begin n = i; break; end
        end
        check("sat_timeout_delay", n, 15 + SYNC_DLY);
        check("sat_no_period_b", int'(period_b), 0);
        check("wide_still_measuring", int'(meas_a), 1);

        // one-cycle en drop, then one-cycle rst, mid-measure at cnt=7
        for (int variant = 0; variant < 2; variant++) begin
            restart(0, 0);
            one_rise(7);
            seen_pv = 0; seen_to = 0;
            cur_exp_period = 12;
            if (variant == 0) en = 1'b0; else rst = 1'b1;
            step();
            en = 1'b1; rst = 1'b0;
            step();
            check("drop_no_strobe", seen_pv + seen_to, 0);
            one_rise(12);
            one_rise(6);
            check("rearm_valids", seen_pv, 1);
            cur_exp_period = -1;
        end

        // randomized traffic against the model
        restart(0, 0);
        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 99) == 0) en = ~en;
            else if (!en && $urandom_range(0, 9) == 0) en = 1'b1;
            if ($urandom_range(0, 63) == 0) begin
                lim_a = ($urandom_range(0, 3) == 0) ? 25'd0 : 25'($urandom_range(1, 30));
                lim_b = 4'($urandom_range(0, 15));
            end
            if ($urandom_range(0, 3) != 0) pulse_in = ($urandom_range(0, 6) == 0);
            step();
        end
        rst = 1'b0;
        pulse_in = 1'b0;
        repeat (5) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
